// File: rtl/ag6502_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ag6502_timer_pkg
//  Brief   : Register offsets, CTRL layout and status packing for the timer.
//  Revision: 1.0 - initial release
// ============================================================================
package ag6502_timer_pkg;

    localparam logic [2:0] c_REG_CNT       = 3'd0;  // rd CNT[7:0]  / wr RELOAD[7:0]
    localparam logic [2:0] c_REG_RELOAD_HI = 3'd1;  // rd SNAP      / wr RELOAD[15:8]
    localparam logic [2:0] c_REG_CTRL      = 3'd2;
    localparam logic [2:0] c_REG_STATUS    = 3'd3;
    localparam logic [2:0] c_REG_PRESC     = 3'd4;

    typedef struct packed {
        logic nmi_en;
        logic irq_en;
        logic oneshot;
        logic en;
    } ctrl_t;

    function automatic logic [7:0] f_status(input logic uf, input ctrl_t ctrl);
        return {uf & ctrl.irq_en, 6'b000000, uf};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ag6502_prescaler.sv
`default_nettype none
// ============================================================================
//  Module  : ag6502_prescaler
//  Brief   : 8-bit down-count divider; one tick every (presc+1) running clocks.
//  Revision: 1.0 - initial release
// ============================================================================
module ag6502_prescaler (
    input  logic       baseclk,
    input  logic       rst,
    input  logic       i_run,
    input  logic       i_restart,
    input  logic [7:0] i_presc,
    output logic       o_tick
);

    logic [7:0] r_count;

    // The count holds while the timer is stopped so a restart defines the phase.
    always_ff @(posedge baseclk or posedge rst) begin
        if (rst) begin
            r_count <= 8'h00;
        end else if (i_restart) begin
            r_count <= i_presc;
        end else if (i_run) begin
            if (r_count == 8'h00) begin
                r_count <= i_presc;
            end else begin
                r_count <= r_count - 8'h01;
            end
        end
    end

    assign o_tick = i_run & ~i_restart & (r_count == 8'h00);

endmodule
`default_nettype wire

// File: rtl/ag6502_timer_responder.sv
`default_nettype none
// ============================================================================
//  Module  : ag6502_timer_responder
//  Brief   : Memory-mapped 16-bit down-counter timer on the ag6502 bus.
//  Revision: 1.0 - initial release
// ============================================================================
module ag6502_timer_responder
    import ag6502_timer_pkg::*;
#(
    parameter logic [15:0] BASE      = 16'hC0F0,
    parameter logic [7:0]  RD_UNUSED = 8'h00
) (
    input  logic        baseclk,
    input  logic        rst,
    input  logic        phi_2,
    input  logic [15:0] ab,
    input  logic        read,
    input  logic [7:0]  db_w,
    output logic [7:0]  db_r,
    output logic        db_oe,
    output logic        irq,
    output logic        nmi
);

    logic        r_phi2_q;
    logic [15:0] r_cnt;
    logic [15:0] r_reload;
    logic [7:0]  r_snap;
    logic [7:0]  r_presc;
    ctrl_t       r_ctrl;
    logic        r_uf;

    logic        w_rise;
    logic        w_fall;
    logic        w_sel;
    logic [2:0]  w_off;
    logic        w_wr;
    logic        w_rd_rise;
    logic        w_rd_fall;
    logic        w_wr_ctrl;
    logic        w_restart;
    logic        w_tick;
    logic        w_en_eff;
    logic        w_oneshot_eff;
    logic        w_count;
    logic        w_uf_set;
    logic        w_uf_clr;
    logic [7:0]  w_rd_data;

    assign w_rise    = phi_2 & ~r_phi2_q;
    assign w_fall    = ~phi_2 & r_phi2_q;
    assign w_sel     = (ab[15:3] == BASE[15:3]);
    assign w_off     = ab[2:0];
    assign w_wr      = w_fall & w_sel & ~read;
    assign w_rd_rise = w_rise & w_sel & read;
    assign w_rd_fall = w_fall & w_sel & read;
    assign w_wr_ctrl = w_wr & (w_off == c_REG_CTRL);
    assign w_restart = w_wr & (w_off == c_REG_RELOAD_HI);

    // A CTRL write landing on a tick clock decides whether that tick counts.
    assign w_en_eff      = w_wr_ctrl ? db_w[0] : r_ctrl.en;
    assign w_oneshot_eff = w_wr_ctrl ? db_w[1] : r_ctrl.oneshot;
    assign w_count       = w_tick & w_en_eff;
    assign w_uf_set      = w_count & (r_cnt == 16'h0000);
    assign w_uf_clr      = w_rd_fall & (w_off == c_REG_STATUS);

    ag6502_prescaler u_prescaler (
        .baseclk   (baseclk),
        .rst       (rst),
        .i_run     (r_ctrl.en),
        .i_restart (w_restart),
        .i_presc   (r_presc),
        .o_tick    (w_tick)
    );

    always_comb begin
        w_rd_data = RD_UNUSED;
        case (w_off)
            c_REG_CNT:       w_rd_data = r_cnt[7:0];
            c_REG_RELOAD_HI: w_rd_data = r_snap;
            c_REG_CTRL:      w_rd_data = {4'b0000, r_ctrl};
            c_REG_STATUS:    w_rd_data = f_status(r_uf, r_ctrl);
            c_REG_PRESC:     w_rd_data = r_presc;
            default:         w_rd_data = RD_UNUSED;
        endcase
    end

    always_ff @(posedge baseclk or posedge rst) begin
        if (rst) begin
            r_phi2_q <= 1'b0;
            db_r     <= 8'h00;
            db_oe    <= 1'b0;
        end else begin
            r_phi2_q <= phi_2;
            if (w_rd_rise) begin
                db_r  <= w_rd_data;
                db_oe <= 1'b1;
            end else if (w_fall) begin
                db_oe <= 1'b0;
            end
        end
    end

    // Register file and counter; later assignments carry the higher priority.
    always_ff @(posedge baseclk or posedge rst) begin
        if (rst) begin
            r_cnt    <= 16'hFFFF;
            r_reload <= 16'hFFFF;
            r_snap   <= 8'h00;
            r_presc  <= 8'h00;
            r_ctrl   <= '0;
            r_uf     <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= ctrl_t'(db_w[3:0]);
            end
            if (w_wr && (w_off == c_REG_PRESC)) begin
                r_presc <= db_w;
            end
            if (w_wr && (w_off == c_REG_CNT)) begin
                r_reload[7:0] <= db_w;
            end
            if (w_rd_rise && (w_off == c_REG_CNT)) begin
                r_snap <= r_cnt[15:8];
            end

            if (w_restart) begin
                r_reload[15:8] <= db_w;
                r_cnt          <= {db_w, r_reload[7:0]};
            end else if (w_uf_set) begin
                r_cnt <= r_reload;
                if (w_oneshot_eff) begin
                    r_ctrl.en <= 1'b0;
                end
            end else if (w_count) begin
                r_cnt <= r_cnt - 16'h0001;
            end

            if (w_restart) begin
                r_uf <= 1'b0;
            end else if (w_uf_set) begin
                r_uf <= 1'b1;
            end else if (w_uf_clr) begin
                r_uf <= 1'b0;
            end
        end
    end

    always_ff @(posedge baseclk or posedge rst) begin
        if (rst) begin
            irq <= 1'b1;
            nmi <= 1'b1;
        end else begin
            irq <= ~(r_uf & r_ctrl.irq_en);
            nmi <= ~(r_uf & r_ctrl.nmi_en);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ag6502_timer_responder.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ag6502_timer_responder
//  Brief   : Bus-cycle bench with an expected-read-data scoreboard.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_ag6502_timer_responder;

    localparam logic [15:0] c_BASE      = 16'hC0F0;
    localparam logic [7:0]  c_RD_UNUSED = 8'hA5;

    logic        baseclk = 1'b0;
    logic        rst;
    logic        phi_2;
    logic [15:0] ab;
    logic        read;
    logic [7:0]  db_w;
    logic [7:0]  db_r;
    logic        db_oe;
    logic        irq;
    logic        nmi;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        oe_at_n3;
    logic [7:0]  q_exp[$];
    string       q_tag[$];

    always #5 baseclk = ~baseclk;

    ag6502_timer_responder #(
        .BASE      (c_BASE),
        .RD_UNUSED (c_RD_UNUSED)
    ) u_dut (
        .baseclk (baseclk),
        .rst     (rst),
        .phi_2   (phi_2),
        .ab      (ab),
        .read    (read),
        .db_w    (db_w),
        .db_r    (db_r),
        .db_oe   (db_oe),
        .irq     (irq),
        .nmi     (nmi)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle: 3 clocks phi_1, 4 clocks phi_2, returns one clock after the fall.
    task automatic bus_cycle(input logic [15:0] a, input logic rd, input logic [7:0] d);
        logic [7:0] e;
        string      t;
        @(negedge baseclk);
        ab = a; read = rd; db_w = d;
        repeat (2) @(negedge baseclk);
        phi_2 = 1'b1;
        @(negedge baseclk);
        oe_at_n3 = db_oe;
        if (db_oe) begin
            if (q_exp.size() == 0) begin
                check("spurious_oe", 16'(db_oe), 16'd0);
            end else begin
                e = q_exp.pop_front();
                t = q_tag.pop_front();
                check(t, 16'(db_r), 16'(e));
            end
        end else if (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            t = q_tag.pop_front();
            check({t, "_no_oe"}, 16'(db_oe), 16'd1);
        end
        repeat (3) @(negedge baseclk);
        phi_2 = 1'b0;
        @(negedge baseclk);
    endtask

    task automatic wr_reg(input logic [2:0] off, input logic [7:0] d);
        bus_cycle(c_BASE | {13'd0, off}, 1'b0, d);
    endtask

    task automatic rd_reg(input logic [2:0] off, input logic [7:0] exp, input string tag);
        q_exp.push_back(exp);
        q_tag.push_back(tag);
        bus_cycle(c_BASE | {13'd0, off}, 1'b1, 8'h00);
        check({tag, "_oe_drop"}, 16'(db_oe), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int dly;
        rst = 1'b1; phi_2 = 1'b0; ab = 16'h0000; read = 1'b1; db_w = 8'h00;
        repeat (3) @(negedge baseclk);
        rst = 1'b0;

        // Reset asserted in the middle of a STATUS read.
        @(negedge baseclk);
        ab = c_BASE | 16'd3; read = 1'b1;
        repeat (2) @(negedge baseclk);
        phi_2 = 1'b1;
        @(negedge baseclk);
        check("pre_rst_oe", 16'(db_oe), 16'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_oe", 16'(db_oe), 16'd0);
        check("rst_db_r", 16'(db_r), 16'h00);
        check("rst_irq", 16'(irq), 16'd1);
        check("rst_nmi", 16'(nmi), 16'd1);
        @(negedge baseclk);
        phi_2 = 1'b0;
        repeat (2) @(negedge baseclk);
        rst = 1'b0;

        rd_reg(3'd3, 8'h00, "rst_status");
        rd_reg(3'd0, 8'hFF, "rst_cnt_lo");
        rd_reg(3'd1, 8'hFF, "rst_snap");
        rd_reg(3'd2, 8'h00, "rst_ctrl");
        rd_reg(3'd4, 8'h00, "rst_presc");

        // Periodic run, RELOAD=3: underflow on the 4th tick, irq one clock later.
        wr_reg(3'd4, 8'h00);
        wr_reg(3'd0, 8'h03);
        wr_reg(3'd1, 8'h00);
        wr_reg(3'd2, 8'h05);
        repeat (4) @(negedge baseclk);
        check("irq_before_uf", 16'(irq), 16'd1);
        @(negedge baseclk);
        check("irq_after_uf", 16'(irq), 16'd0);
        wr_reg(3'd2, 8'h04);
        rd_reg(3'd3, 8'h81, "status_uf_irq");
        check("irq_held_at_fall", 16'(irq), 16'd0);
        @(negedge baseclk);
        check("irq_released", 16'(irq), 16'd1);

        // One-shot: a single underflow clears EN and leaves CNT at RELOAD.
        wr_reg(3'd0, 8'h02);
        wr_reg(3'd1, 8'h00);
        wr_reg(3'd2, 8'h07);
        rd_reg(3'd2, 8'h06, "oneshot_ctrl");
        rd_reg(3'd0, 8'h02, "oneshot_cnt");
        rd_reg(3'd3, 8'h81, "oneshot_status");
        rd_reg(3'd3, 8'h00, "oneshot_status_clr");

        // RELOAD=7 underflows exactly on each following STATUS-read fall.
        wr_reg(3'd2, 8'h01);
        wr_reg(3'd0, 8'h07);
        wr_reg(3'd1, 8'h00);
        rd_reg(3'd3, 8'h00, "coll_status_a");
        rd_reg(3'd3, 8'h01, "coll_uf_kept");
        wr_reg(3'd2, 8'h00);
        rd_reg(3'd3, 8'h01, "coll_uf_after_stop");
        rd_reg(3'd3, 8'h00, "coll_uf_cleared");
        rd_reg(3'd0, 8'h00, "coll_ctrl_wins");

        // RELOAD[15:8] write on a tick clock: CNT=0x0020, UF cleared, 11 ticks to the read.
        wr_reg(3'd2, 8'h01);
        wr_reg(3'd0, 8'h20);
        wr_reg(3'd1, 8'h00);
        rd_reg(3'd3, 8'h00, "reload_clears_uf");
        rd_reg(3'd0, 8'h15, "reload_beats_tick");

        // Atomic 16-bit read: 3 ticks from the reload to the low-byte read.
        wr_reg(3'd0, 8'h03);
        wr_reg(3'd1, 8'h01);
        rd_reg(3'd0, 8'h00, "atomic_lo");
        rd_reg(3'd1, 8'h01, "atomic_snap");
        rd_reg(3'd0, 8'hF0, "atomic_lo2");
        rd_reg(3'd1, 8'h00, "atomic_snap2");

        // NMI: 10 prescaled clocks to underflow plus one register stage.
        wr_reg(3'd2, 8'h00);
        wr_reg(3'd4, 8'h09);
        wr_reg(3'd0, 8'h00);
        wr_reg(3'd1, 8'h00);
        wr_reg(3'd2, 8'h09);
        dly = 0;
        while (nmi !== 1'b0 && dly < 40) begin
            @(negedge baseclk);
            dly++;
        end
        check("nmi_delay", 16'(dly), 16'd11);
        check("nmi_irq_quiet", 16'(irq), 16'd1);

        rd_reg(3'd6, c_RD_UNUSED, "unused_off6");
        bus_cycle(c_BASE - 16'd8 + 16'd3, 1'b1, 8'h00);
        check("miss_read_oe", 16'(oe_at_n3), 16'd0);
        bus_cycle(c_BASE + 16'd8 + 16'd2, 1'b0, 8'h00);
        rd_reg(3'd2, 8'h09, "miss_write_ctrl");
        check("nmi_held", 16'(nmi), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
